// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg -- shared types and constants for the RV32I load/store unit.
//   lsu_state_e    : access FSM states (IDLE/REQ/WAIT/DONE)
//   F3_*           : RV32I funct3 encodings for loads and stores
//   is_misaligned  : natural-alignment test used when the misalign trap
//                    (LSU_MISALIGN_TRAP_EN) is built in
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Halfwords need addr[0]=0, words (including the unused 11 size code)
    // need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        case (funct3[1:0])
            F3_LB[1:0]: is_misaligned = 1'b0;
            F3_LH[1:0]: is_misaligned = addr_lo[0];
            default:    is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align -- combinational lane logic for the load/store unit.
//   funct3    in  3   RV32I width/sign field
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  raw store data (rs2)
//   rdata     in  32  raw read word from memory
//   be        out 4   byte enables
//   wdata_rep out 32  store data replicated across the addressed lanes
//   rdata_ext out 32  selected and sign/zero-extended load data
// Halfwords use only addr_lo[1] and words ignore addr_lo, so misaligned
// addresses fall back to the containing aligned lane.
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sign_en;

    // funct3[2] set means the unsigned variant (LBU/LHU).
    assign sign_en = ~funct3[2];

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
        lane_b    = rdata[7:0];
        lane_h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (addr_lo)
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            2'd3:    lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase

        case (funct3[1:0])
            F3_LB[1:0]: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{sign_en & lane_b[7]}}, lane_b};
            end
            F3_LH[1:0]: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{sign_en & lane_h[15]}}, lane_h};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- RV32I load/store unit: one data-memory access per instruction over a
// req/gnt/rvalid handshake, stalling execute until the response returns.
//   clk, rst              core clock, synchronous active-high reset
//   valid_i/we_i/funct3_i execute-stage request, store flag, width/sign
//   addr_i/wdata_i        effective address and store data
//   busy_o                stall request to the core
//   done_o                one-cycle completion pulse (qualifies rdata_o/misalign_o)
//   rdata_o               extended load data, 0 for stores
//   misalign_o            misaligned-access flag
//   mem_req/we/addr/be/wdata  memory request channel (registered, stable in REQ)
//   mem_gnt/rvalid/rdata  memory handshake and read data
// Build option: LSU_MISALIGN_TRAP_EN -- misaligned halfword/word accesses skip
// the memory and complete immediately with misalign_o=1. Without it the flag
// is tied low and misaligned addresses use the containing aligned lane.
// -----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_addr_lo;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] rdata_c;
    logic        trap_c;

    // In IDLE the lane logic works on the incoming request (to load the
    // request registers); afterwards it works on the captured fields (to
    // extend the returning read word).
    assign sel_funct3  = (state == IDLE) ? funct3_i     : funct3_q;
    assign sel_addr_lo = (state == IDLE) ? addr_i[1:0]  : addr_lo_q;

    lsu_align u_align (
        .funct3    (sel_funct3),
        .addr_lo   (sel_addr_lo),
        .wdata     (wdata_i),
        .rdata     (mem_rdata),
        .be        (be_c),
        .wdata_rep (wdata_c),
        .rdata_ext (rdata_c)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_c = is_misaligned(funct3_i, addr_i[1:0]);
`else
    assign trap_c = 1'b0;
`endif

    // NOTE: busy_o must include valid_i in IDLE so the core stalls in the
    // request cycle itself; it is therefore combinational, not registered.
    assign busy_o = ((state == IDLE) && valid_i) || (state == REQ) || (state == WAIT);
    assign done_o = (state == DONE);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            rdata_o    <= 32'h0;
            misalign_o <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_be     <= 4'h0;
            mem_wdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    misalign_o <= 1'b0;
                    if (valid_i) begin
                        funct3_q  <= funct3_i;
                        addr_lo_q <= addr_i[1:0];
                        if (trap_c) begin
                            state      <= DONE;
                            misalign_o <= 1'b1;
                            rdata_o    <= 32'h0;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= we_i;
                            mem_addr  <= {addr_i[31:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_o <= mem_we ? 32'h0 : rdata_c;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    misalign_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu. Expected values come from a byte-level
// model: an access covers n bytes at the n-aligned offset, store data repeats
// the low n bytes, loads shift the word down and extend from bit 8n-1.
// -----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    lsu dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .we_i       (we_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .misalign_o (misalign_o),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done_o) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int n, off;
        n   = nbytes(f3);
        off = int'(a[1:0]);
        return off - (off % n);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return 4'(((1 << n) - 1) << lane_off(f3, a));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] rd);
        logic [31:0] v, mask;
        int n;
        n = nbytes(f3);
        v = rd >> (8 * lane_off(f3, a));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v    = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        return (int'(a[1:0]) % nbytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Runs one access starting in an IDLE cycle (called at posedge+1) and
    // returns at posedge+1 of the cycle after DONE.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int gd, input int rvd, input logic early);
        int   d0;
        logic mis;
        d0  = done_cnt;
        mis = exp_mis(f3, a);
        valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = ~rd;
        @(negedge clk);
        check("idle_busy", busy_o, 1'b1);
        check("idle_done", done_o, 1'b0);
        check("idle_req", mem_req, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        if (mis) begin
            @(negedge clk);
            check("trap_done", done_o, 1'b1);
            check("trap_mis", misalign_o, 1'b1);
            check("trap_req", mem_req, 1'b0);
            check("trap_busy", busy_o, 1'b0);
        end else begin
            for (int c = 0; c <= gd; c++) begin
                mem_gnt    = (c == gd);
                mem_rvalid = early;
                @(negedge clk);
                check("req_req", mem_req, 1'b1);
                check("req_addr", mem_addr, {a[31:2], 2'b00});
                check("req_be", mem_be, exp_be(f3, a));
                check("req_we", mem_we, we);
                if (we) check("req_wdata", mem_wdata, exp_wdata(f3, wd));
                check("req_busy", busy_o, 1'b1);
                check("req_done", done_o, 1'b0);
                @(posedge clk); #1;
            end
            mem_gnt = 1'b0;
            for (int c = 0; c <= rvd; c++) begin
                mem_rvalid = (c == rvd);
                mem_rdata  = (c == rvd) ? rd : ~rd;
                @(negedge clk);
                check("wait_req", mem_req, 1'b0);
                check("wait_busy", busy_o, 1'b1);
                check("wait_done", done_o, 1'b0);
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b0;
            mem_rdata  = ~rd;
            @(negedge clk);
            check("done_done", done_o, 1'b1);
            check("done_busy", busy_o, 1'b0);
            check("done_req", mem_req, 1'b0);
            check("done_rdata", rdata_o, we ? 32'h0 : exp_rdata(f3, a, rd));
            check("done_mis", misalign_o, 1'b0);
        end
        @(posedge clk); #1;
        check("done_once", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_req"}, mem_req, 1'b0);
        check({tag, "_we"}, mem_we, 1'b0);
        check({tag, "_addr"}, mem_addr, 32'h0);
        check({tag, "_be"}, mem_be, 4'h0);
        check({tag, "_wdata"}, mem_wdata, 32'h0);
        check({tag, "_rdata"}, rdata_o, 32'h0);
        check({tag, "_mis"}, misalign_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h0; wdata_i = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk); #1;

        // Directed cases.
        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0);        // SW
        access(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1'b0);        // SB
        access(1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 0, 0, 1'b0);        // LB
        access(1'b0, 3'b100, 32'h101, 32'h0, 32'h00008000, 0, 0, 1'b0);        // LBU
        access(1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF0000, 0, 0, 1'b0);        // LHU
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80010000, 1, 1, 1'b0);        // LH
        access(1'b1, 3'b001, 32'h202, 32'h1234CAFE, 32'h0, 0, 1, 1'b0);        // SH
        access(1'b0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 3, 2, 1'b1);        // LW, delays
        access(1'b0, 3'b010, 32'h102, 32'h0, 32'hA5A55A5A, 0, 0, 1'b0);        // misaligned LW
        access(1'b0, 3'b001, 32'h101, 32'h0, 32'h0000FF00, 0, 0, 1'b0);        // misaligned LH

        // Reset while waiting for rvalid, then a stale rvalid.
        valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h200;
        @(posedge clk); #1;
        valid_i = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        check("rstw_busy", busy_o, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check_reset_outputs("rstw1");
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_reset_outputs("rstw2");
        @(posedge clk); #1;

        // Randomized accesses, back-to-back.
        for (int i = 0; i < 150; i++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core: consumes the ALU's effective-address result plus rs2 store data and funct3. It issues one data-memory access per instruction over a req/gnt/rvalid handshake, generates byte enables and store-lane replication, and returns sign- or zero-extended load data for writeback. It stalls the execute stage while an access is outstanding and is reused unchanged by the single-cycle and pipelined cores.

## Interface
- No parameters. Widths are fixed at 32-bit data and address.
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  execute stage presents a load/store; operands held stable while busy_o=1
- we_i  in  1  1=store, 0=load
- funct3_i  in  3  RV32I width/sign field
- addr_i  in  32  effective address (ALU result)
- wdata_i  in  32  store data (rs2)
- busy_o  out  1  stall request to the core
- done_o  out  1  one-cycle pulse: access complete; rdata_o/misalign_o valid
- rdata_o  out  32  extended load data (0 for stores)
- misalign_o  out  1  misaligned-access flag, qualified by done_o
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  response valid (loads and stores)
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when valid_i=1, capture addr_i, we_i, funct3_i and wdata_i, then go to REQ. If valid_i=0, stay in IDLE.
- REQ: mem_req=1 with all mem_* outputs driven from the captured registers and held stable. On mem_gnt=1, go to WAIT.
- WAIT: mem_req=0. On mem_rvalid=1, register the extended load data, then go to DONE.
- DONE: done_o=1. Next state is IDLE unconditionally. valid_i is ignored because the core advances this cycle.
- busy_o = (IDLE & valid_i) | REQ | WAIT. It is 0 in DONE.
- Byte enables:
  - Byte access (funct3[1:0]=00): be = 4'b0001 << addr[1:0].
  - Halfword (01): be = addr[1] ? 4'b1100 : 4'b0011.
  - Word (10): be = 4'b1111.
  - funct3[1:0]=11: treated as word.
- Store data: SB replicates wdata[7:0] to all four lanes; SH replicates wdata[15:0] to both halves; SW passes wdata through.
- Loads select the byte or halfword lane by addr[1:0]. LB and LH sign-extend; LBU and LHU zero-extend. LW passes the word through. Unused funct3 codes load as LW.
- Stores complete on mem_rvalid with rdata_o=0.

## Timing
- Reset values: state=IDLE. busy_o, done_o, rdata_o, misalign_o, mem_req, mem_we, mem_addr, mem_be and mem_wdata are all 0.
- Minimum latency, with mem_gnt in the REQ cycle and mem_rvalid in the next cycle:
  - Cycle 0: IDLE with valid_i.
  - Cycle 1: REQ with gnt.
  - Cycle 2: WAIT with rvalid.
  - Cycle 3: DONE.
  - Total is 4 cycles, with busy_o high for cycles 0–2.
- Wait states on mem_gnt or mem_rvalid extend REQ or WAIT indefinitely. There is no timeout.
- mem_rvalid is sampled only in WAIT. An rvalid arriving in IDLE, REQ or DONE is ignored.
- A new access can begin in the IDLE cycle immediately after DONE.
- Reset asserted mid-access: next cycle is IDLE with mem_req=0 and no done_o. A stale rvalid after reset is ignored.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, goes from IDLE directly to DONE.
  - In that DONE cycle, misalign_o=1 and done_o=1, and no mem_req is issued.
  - busy_o is 1 in the IDLE cycle only.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalign_o is tied to 0.
  - Halfword accesses ignore addr[0], and word accesses ignore addr[1:0], for both be and lane selection.

## Structure
- Package lsu_pkg contains:
  - the lsu_state_e enum (IDLE/REQ/WAIT/DONE);
  - funct3 localparams F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, F3_SB=000, F3_SH=001, F3_SW=010.
- Sub-module lsu_align: purely combinational. It generates be, replicates store data and extends load data from funct3 and addr[1:0].
- Top-level lsu holds the FSM and the capture registers.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, gnt and rvalid with zero wait → mem_addr=0x100, be=1111, mem_wdata=0xDEADBEEF; done_o in cycle 3; busy_o high for cycles 0–2.
- SB addr=0x103, wdata=0x000000A5 → be=1000, mem_wdata=0xA5A5A5A5.
- LB addr=0x101, mem_rdata=0x00008000 → rdata_o=0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr=0x102, mem_rdata=0xBEEF0000 → 0x0000BEEF.
- LW with 3-cycle gnt delay and 2-cycle rvalid delay → mem_req and mem_addr stable until gnt; rvalid injected during REQ is ignored; done_o exactly once.
- LW addr=0x102 with LSU_MISALIGN_TRAP_EN → no mem_req; done_o=1 and misalign_o=1 one cycle after valid_i. Without the macro → mem_addr=0x100, be=1111, misalign_o=0.
- rst asserted during WAIT, then rvalid pulsed → IDLE next cycle; done_o stays 0; all outputs at reset values.
